// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: op index + register/immediate fields -> 32-bit word.
// Illegal ops and out-of-range immediates become the canonical NOP with out_err set.
// Words leave through a valid/ready stream backed by a main register plus one skid entry.
module rv32i_instr_encoder #(
  parameter int CNT_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [CNT_W-1:0]     out_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_F, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_instr;
  logic        enc_err;

  // Immediate range checks, written as sign-extension tests on the upper bits.
  logic imm_i_ok, imm_sh_ok, imm_b_ok, imm_j_ok, imm_u_ok, imm_f_ok;
  assign imm_i_ok  = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign imm_sh_ok = (in_imm[31:5] == '0);
  assign imm_b_ok  = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
  assign imm_j_ok  = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
  assign imm_u_ok  = (in_imm[11:0] == '0);
  assign imm_f_ok  = (in_imm[31:12] == '0);

  // Op index -> format, opcode, funct3, funct7.
  always_comb begin
    fmt = FMT_BAD;
    opc = OPC_IMM;
    f3  = 3'd0;
    f7  = 7'h00;
    case (in_op)
      6'd0:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd0; end
      6'd1:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd0; f7 = 7'h20; end
      6'd2:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd1; end
      6'd3:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd2; end
      6'd4:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd3; end
      6'd5:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd4; end
      6'd6:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd5; end
      6'd7:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd5; f7 = 7'h20; end
      6'd8:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd6; end
      6'd9:  begin fmt = FMT_R;  opc = OPC_R;      f3 = 3'd7; end
      6'd10: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd0; end
      6'd11: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd1; end
      6'd12: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd2; end
      6'd13: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd4; end
      6'd14: begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'd5; end
      6'd15: begin fmt = FMT_F;  opc = OPC_FENCE;  f3 = 3'd0; end
      6'd16: begin fmt = FMT_F;  opc = OPC_FENCE;  f3 = 3'd1; end
      6'd17: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd0; end
      6'd18: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd1; end
      6'd19: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd2; end
      6'd20: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd3; end
      6'd21: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd4; end
      6'd22: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd5; end
      6'd23: begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'd5; f7 = 7'h20; end
      6'd24: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd6; end
      6'd25: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'd7; end
      6'd26: begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      6'd27: begin fmt = FMT_U;  opc = OPC_LUI;    end
      6'd28: begin fmt = FMT_J;  opc = OPC_JAL;    end
      6'd29: begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'd0; end
      6'd30: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd0; end
      6'd31: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd1; end
      6'd32: begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'd2; end
      6'd33: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd0; end
      6'd34: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd1; end
      6'd35: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd4; end
      6'd36: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd5; end
      6'd37: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd6; end
      6'd38: begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'd7; end
      default: fmt = FMT_BAD;
    endcase
  end

  // Field assembly per format; unused register fields are zero by construction.
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (fmt)
      FMT_R:  enc_instr = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      FMT_I:  begin
        enc_instr = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_err   = !imm_i_ok;
      end
      FMT_SH: begin
        enc_instr = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
        enc_err   = !imm_sh_ok;
      end
      FMT_F:  begin
        enc_instr = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_err   = !imm_f_ok;
      end
      FMT_S:  begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
        enc_err   = !imm_i_ok;
      end
      FMT_B:  begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
        enc_err   = !imm_b_ok;
      end
      FMT_U:  begin
        enc_instr = {in_imm[31:12], in_rd, opc};
        enc_err   = !imm_u_ok;
      end
      FMT_J:  begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_err   = !imm_j_ok;
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_instr = NOP;
  end

  logic                 main_vld_q, main_vld_d, main_err_q, main_err_d;
  logic [31:0]          main_instr_q, main_instr_d;
  logic                 skid_vld_q, skid_vld_d, skid_err_q, skid_err_d;
  logic [31:0]          skid_instr_q, skid_instr_d;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 handoff, accept;

  // Next-state for the two-entry FIFO and counters; skid refills main when main drains.
  always_comb begin
    handoff      = main_vld_q && out_ready;
    accept       = in_valid && in_ready_q;
    main_vld_d   = main_vld_q;
    main_instr_d = main_instr_q;
    main_err_d   = main_err_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;
    if (handoff && skid_vld_q) begin
      // in_ready is low here, so no new word can arrive this cycle
      main_vld_d   = 1'b1;
      main_instr_d = skid_instr_q;
      main_err_d   = skid_err_q;
      skid_vld_d   = 1'b0;
    end else if (handoff || !main_vld_q) begin
      main_vld_d = accept;
      if (accept) begin
        main_instr_d = enc_instr;
        main_err_d   = enc_err;
      end
    end else if (accept) begin
      skid_vld_d   = 1'b1;
      skid_instr_d = enc_instr;
      skid_err_d   = enc_err;
    end
    in_ready_d = !skid_vld_d;
    out_cnt_d  = handoff ? out_cnt_q + CNT_W'(1) : out_cnt_q;
    err_cnt_d  = (handoff && main_err_q && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
  end

  // State registers with synchronous reset that discards both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q   <= 1'b0;
      main_instr_q <= NOP;
      main_err_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      out_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      main_vld_q   <= main_vld_d;
      main_instr_q <= main_instr_d;
      main_err_q   <= main_err_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
      out_cnt_q    <= out_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_instr = main_instr_q;
  assign out_err   = main_err_q;
  assign out_cnt   = out_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
